// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (common with the receiver), widths and parity helper.
package uart_pkg;

   // Code 3'b101 is only used when UART_TX_PARITY_EN is defined; otherwise it is illegal.
   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      START   = 3'b001,
      DATA    = 3'b010,
      STOP    = 3'b011,
      CLEANUP = 3'b100,
      PARITY  = 3'b101
   } uart_state_t;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_CNT_W     = 16;

   // Even parity bit: makes the total count of ones (data + parity) even.
   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-request / serial-line bundle for the UART transmitter.
interface uart_tx_if;
   import uart_pkg::*;

   logic                      i_Enable;
   logic                      i_Tx_DV;
   logic [UART_DATA_BITS-1:0] i_Tx_Byte;
   logic                      o_Tx_Serial;
   logic                      o_Tx_Active;
   logic                      o_Tx_Done;

   // Byte producer side.
   modport master (
      output i_Enable,
      output i_Tx_DV,
      output i_Tx_Byte,
      input  o_Tx_Serial,
      input  o_Tx_Active,
      input  o_Tx_Done
   );

   // Transmitter side.
   modport slave (
      input  i_Enable,
      input  i_Tx_DV,
      input  i_Tx_Byte,
      output o_Tx_Serial,
      output o_Tx_Active,
      output o_Tx_Done
   );

endinterface

// File: rtl/uart_tx_baud_counter.sv
// Bit-time counter: counts clock cycles within one bit and flags the last cycle of the bit.
module uart_tx_baud_counter
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   // Terminal count, truncated to the counter width so 65536 still fits.
   localparam logic [UART_CNT_W-1:0] LAST_CNT = UART_CNT_W'(CLKS_PER_BIT - 1);

   logic [UART_CNT_W-1:0] count_q;
   logic [UART_CNT_W-1:0] count_d;

   // Next count: restart on clear, otherwise advance by one.
   always_comb begin
      count_d = count_q + UART_CNT_W'(1);
      if (clear) begin
         count_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bit_end = (count_q == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, registered serial/active/done outputs.
// Optional even-parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   uart_tx_if.slave    tx_bus
);

   uart_state_t               state_q, state_d;
   logic [2:0]                index_q, index_d;
   logic [UART_DATA_BITS-1:0] byte_q, byte_d;
   logic                      serial_q, serial_d;
   logic                      active_q, active_d;
   logic                      done_q, done_d;
   logic                      bit_end;
   logic                      cnt_clear;

   // Counter runs only while a bit is on the line; it restarts at every bit boundary.
   always_comb begin
      cnt_clear = 1'b1;
      case (state_q)
         START, DATA, STOP: cnt_clear = bit_end;
`ifdef UART_TX_PARITY_EN
         PARITY:            cnt_clear = bit_end;
`endif
         default:           cnt_clear = 1'b1;
      endcase
   end

   uart_tx_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk     (i_Clock),
      .rst     (i_Reset),
      .clear   (cnt_clear),
      .bit_end (bit_end)
   );

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      byte_d   = byte_q;
      serial_d = serial_q;
      active_d = active_q;
      done_d   = done_q;

      case (state_q)
         IDLE: begin
            serial_d = 1'b1;
            done_d   = 1'b0;
            index_d  = 3'd0;
            if (tx_bus.i_Tx_DV && tx_bus.i_Enable) begin
               byte_d   = tx_bus.i_Tx_Byte;
               serial_d = 1'b0;
               active_d = 1'b1;
               state_d  = START;
            end
         end

         START: begin
            if (bit_end) begin
               serial_d = byte_q[0];
               state_d  = DATA;
            end
         end

         DATA: begin
            if (bit_end) begin
               if (index_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  serial_d = even_parity(byte_q);
                  state_d  = PARITY;
`else
                  serial_d = 1'b1;
                  state_d  = STOP;
`endif
               end else begin
                  index_d  = index_q + 3'd1;
                  serial_d = byte_q[index_q + 3'd1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               serial_d = 1'b1;
               state_d  = STOP;
            end
         end
`endif

         STOP: begin
            if (bit_end) begin
               done_d   = 1'b1;
               active_d = 1'b0;
               state_d  = CLEANUP;
            end
         end

         CLEANUP: begin
            done_d  = 1'b0;
            index_d = 3'd0;
            state_d = IDLE;
         end

         // Unused codes recover to an idle line.
         default: begin
            serial_d = 1'b1;
            active_d = 1'b0;
            done_d   = 1'b0;
            index_d  = 3'd0;
            state_d  = IDLE;
         end
      endcase
   end

   // State and output registers; reset forces the line high at once.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= IDLE;
         index_q  <= 3'd0;
         byte_q   <= '0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         byte_q   <= byte_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign tx_bus.o_Tx_Serial = serial_q;
   assign tx_bus.o_Tx_Active = active_q;
   assign tx_bus.o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4.
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;     // [0]=start, [8:1]=data LSB first, [9]=stop
      logic       par;       // expected even parity bit
      int         inj_cyc;   // cycle to pulse a second request (-1: none)
      logic [7:0] inj_data;
      int         drop_en;   // cycle to drop i_Enable (-1: never)
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   rx_cnt = 0;
   int   rst_cnt = 0;
   logic [7:0] exp_q[$];
   vec_t vecs[5];

   uart_tx_if tx_bus ();

   uart_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_Clock (clk),
      .i_Reset (rst),
      .tx_bus  (tx_bus)
   );

   always #5 clk = ~clk;

   always @(posedge rst) rst_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_bit(input vec_t v, input int b);
`ifdef UART_TX_PARITY_EN
      if (b < 9) return v.frame[b];
      if (b == 9) return v.par;
      return v.frame[9];
`else
      return v.frame[b];
`endif
   endfunction

   // Receiver model: decodes the serial line mid-bit and checks against the scoreboard.
   initial begin : rx_model
      logic [7:0] d;
      logic       p;
      logic       s;
      int         r0;
      p = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && tx_bus.o_Tx_Serial === 1'b0) begin
            r0 = rst_cnt;
            repeat (2) @(negedge clk);
            if (tx_bus.o_Tx_Serial === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge clk);
                  d[i] = tx_bus.o_Tx_Serial;
               end
`ifdef UART_TX_PARITY_EN
               repeat (CPB) @(negedge clk);
               p = tx_bus.o_Tx_Serial;
`endif
               repeat (CPB) @(negedge clk);
               s = tx_bus.o_Tx_Serial;
               if (rst_cnt == r0 && !rst) begin
                  rx_cnt++;
                  if (exp_q.size() == 0) begin
                     chk("rx_unexpected_frame", 32'(d), 32'hFFFF_FFFF);
                  end else begin
                     logic [7:0] e;
                     e = exp_q.pop_front();
                     chk("rx_data", 32'(d), 32'(e));
                     chk("rx_stop", 32'(s), 32'd1);
`ifdef UART_TX_PARITY_EN
                     chk("rx_parity", 32'(p), 32'(^e));
`endif
                  end
               end
            end
         end
      end
   end

   // One frame with cycle-accurate line, active and done checks.
   task automatic run_frame(input vec_t v, input string tag);
      logic [NBITS-1:0] bad;
      int act_bad;
      int idle_bad;
      int n_done;
      int done_at;
      bad = '0; act_bad = 0; idle_bad = 0; n_done = 0; done_at = -1;
      tx_bus.i_Enable  = 1'b1;
      tx_bus.i_Tx_DV   = 1'b1;
      tx_bus.i_Tx_Byte = v.data;
      exp_q.push_back(v.data);
      for (int c = 0; c <= FRAME + 3; c++) begin
         @(negedge clk);
         if (c == 0) begin
            tx_bus.i_Tx_DV   = 1'b0;
            tx_bus.i_Tx_Byte = ~v.data;
         end
         if (c < FRAME) begin
            if (tx_bus.o_Tx_Serial !== exp_bit(v, c / CPB)) bad[c / CPB] = 1'b1;
            if (tx_bus.o_Tx_Active !== 1'b1) act_bad++;
         end else begin
            if (tx_bus.o_Tx_Serial !== 1'b1) idle_bad++;
            if (tx_bus.o_Tx_Active !== 1'b0) act_bad++;
         end
         if (tx_bus.o_Tx_Done === 1'b1) begin
            n_done++;
            done_at = c;
         end
         if (c == v.inj_cyc) begin
            tx_bus.i_Tx_DV   = 1'b1;
            tx_bus.i_Tx_Byte = v.inj_data;
         end else if (c == v.inj_cyc + 1) begin
            tx_bus.i_Tx_DV = 1'b0;
         end
         if (c == v.drop_en) tx_bus.i_Enable = 1'b0;
      end
      for (int b = 0; b < NBITS; b++) begin
         chk($sformatf("%s_bit%0d", tag, b), 32'(bad[b]), 32'd0);
      end
      chk({tag, "_active_bad_cycles"}, 32'(act_bad), 32'd0);
      chk({tag, "_line_after_frame"}, 32'(idle_bad), 32'd0);
      chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
      chk({tag, "_done_cycle"}, 32'(done_at), 32'(FRAME));
      tx_bus.i_Enable = 1'b1;
   endtask

   initial begin : main
      int bad_cnt;
      vec_t rv;
      vecs[0] = '{8'h55, 10'b1010101010, 1'b0, -1, 8'h00, -1};
      vecs[1] = '{8'hA5, 10'b1101001010, 1'b0, 10, 8'hFF, -1};
      vecs[2] = '{8'h81, 10'b1100000010, 1'b0, -1, 8'h00, 7};
      vecs[3] = '{8'h07, 10'b1000001110, 1'b1, -1, 8'h00, 20};
      vecs[4] = '{8'h00, 10'b1000000000, 1'b0, 30, 8'h5A, -1};
      rv      = '{8'h3C, 10'b1001111000, 1'b0, -1, 8'h00, -1};

      tx_bus.i_Enable  = 1'b0;
      tx_bus.i_Tx_DV   = 1'b0;
      tx_bus.i_Tx_Byte = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_serial", 32'(tx_bus.o_Tx_Serial), 32'd1);
      chk("reset_active", 32'(tx_bus.o_Tx_Active), 32'd0);
      chk("reset_done", 32'(tx_bus.o_Tx_Done), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

      // Requests with i_Enable low are ignored.
      tx_bus.i_Enable  = 1'b0;
      tx_bus.i_Tx_DV   = 1'b1;
      tx_bus.i_Tx_Byte = 8'h99;
      bad_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_bus.o_Tx_Serial !== 1'b1 || tx_bus.o_Tx_Active !== 1'b0) bad_cnt++;
      end
      chk("enable_low_ignored", 32'(bad_cnt), 32'd0);
      tx_bus.i_Tx_DV  = 1'b0;
      tx_bus.i_Enable = 1'b1;
      @(negedge clk);

      // Back-to-back with request held: next start bit at FRAME+2 after first accept.
      tx_bus.i_Tx_DV   = 1'b1;
      tx_bus.i_Tx_Byte = 8'h00;
      exp_q.push_back(8'h00);
      @(negedge clk);
      tx_bus.i_Tx_Byte = 8'hFF;
      exp_q.push_back(8'hFF);
      for (int c = 1; c <= FRAME + 2; c++) begin
         @(negedge clk);
         if (c == FRAME) chk("b2b_done_first", 32'(tx_bus.o_Tx_Done), 32'd1);
         if (c == FRAME + 1) begin
            chk("b2b_cleanup_line", 32'(tx_bus.o_Tx_Serial), 32'd1);
            chk("b2b_cleanup_active", 32'(tx_bus.o_Tx_Active), 32'd0);
         end
         if (c == FRAME + 2) begin
            chk("b2b_second_start", 32'(tx_bus.o_Tx_Serial), 32'd0);
            chk("b2b_second_active", 32'(tx_bus.o_Tx_Active), 32'd1);
            tx_bus.i_Tx_DV = 1'b0;
         end
      end
      repeat (FRAME + 8) @(negedge clk);

      // Asynchronous reset in data bit 3 abandons the frame immediately.
      tx_bus.i_Tx_DV   = 1'b1;
      tx_bus.i_Tx_Byte = 8'hC3;
      @(negedge clk);
      tx_bus.i_Tx_DV = 1'b0;
      repeat (17) @(negedge clk);
      chk("pre_reset_active", 32'(tx_bus.o_Tx_Active), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_serial", 32'(tx_bus.o_Tx_Serial), 32'd1);
      chk("async_reset_active", 32'(tx_bus.o_Tx_Active), 32'd0);
      chk("async_reset_done", 32'(tx_bus.o_Tx_Done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("post_reset_idle_line", 32'(tx_bus.o_Tx_Serial), 32'd1);
      run_frame(rv, "post_reset");

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("rx_frame_count", 32'(rx_cnt), 32'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
